// File: rtl/queue_occupancy_counter.sv
// Bank queue front end: debounces the entry/exit photo-sensors, keeps a
// saturating occupancy count (Pcount) and the open-teller count (Tcount).
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   enter_sens, exit_sens raw (clk-synchronous) door sensors
//   tcount_in, tcount_load teller-count switch and its 1-cycle capture strobe
//   Pcount, Tcount        registered occupancy (0..PMAX) and tellers (1..3)
//   empty, full           registered Pcount==0 / Pcount==PMAX
//   upd                   registered pulse after an edge that changed Pcount or Tcount
//   alarm_clr, alarm      only with QUEUE_OVERFLOW_ALARM_EN: sticky overflow flag
//
// Optional feature macro: QUEUE_OVERFLOW_ALARM_EN
module queue_occupancy_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PMAX            = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_sens,
  input  logic       exit_sens,
  input  logic [1:0] tcount_in,
  input  logic       tcount_load,
`ifdef QUEUE_OVERFLOW_ALARM_EN
  input  logic       alarm_clr,
  output logic       alarm,
`endif
  output logic [2:0] Pcount,
  output logic [1:0] Tcount,
  output logic       empty,
  output logic       full,
  output logic       upd
);

  localparam int unsigned PW  = 3;
  localparam int unsigned TW  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned NS  = 2;
  localparam int unsigned ENT = 0;
  localparam int unsigned EXT = 1;

  localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] P_MAX  = PW'(PMAX);

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} db_state_t;

  db_state_t         state_q [NS];
  db_state_t         state_d [NS];
  logic [CW-1:0]     cnt_q   [NS];
  logic [CW-1:0]     cnt_d   [NS];
  logic [NS-1:0]     ev_q;
  logic [NS-1:0]     ev_d;
  logic [NS-1:0]     sens;
  logic [PW-1:0]     p_d;
  logic [TW-1:0]     t_d;

  assign sens = {exit_sens, enter_sens};

  // Debounce next-state: ev fires once on the accepted rising level.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      ev_d[i]    = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (sens[i]) begin
            if (D_LAST == CW'(1)) begin
              state_d[i] = HELD;
              cnt_d[i]   = '0;
              ev_d[i]    = 1'b1;
            end else begin
              state_d[i] = ARM;
              cnt_d[i]   = CW'(1);
            end
          end
        end
        ARM: begin
          if (!sens[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + CW'(1) == D_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            ev_d[i]    = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        HELD: begin
          if (!sens[i]) begin
            if (D_LAST == CW'(1)) begin
              state_d[i] = IDLE;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = REL;
              cnt_d[i]   = CW'(1);
            end
          end
        end
        REL: begin
          if (sens[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] + CW'(1) == D_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Occupancy next value; invalid half of a simultaneous pair is dropped.
  always_comb begin
    p_d = Pcount;
    case ({ev_q[ENT], ev_q[EXT]})
      2'b10: if (Pcount != P_MAX) p_d = Pcount + PW'(1);
      2'b01: if (Pcount != '0)    p_d = Pcount - PW'(1);
      2'b11: begin
        if (Pcount == '0)         p_d = PW'(1);
        else if (Pcount == P_MAX) p_d = P_MAX - PW'(1);
      end
      default: p_d = Pcount;
    endcase
  end

  // A zero teller count is not a legal setting and is ignored.
  always_comb begin
    t_d = Tcount;
    if (tcount_load && (tcount_in != '0)) t_d = tcount_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      ev_q   <= '0;
      Pcount <= '0;
      Tcount <= TW'(1);
      empty  <= 1'b1;
      full   <= 1'b0;
      upd    <= 1'b0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ev_q   <= ev_d;
      Pcount <= p_d;
      Tcount <= t_d;
      empty  <= (p_d == '0);
      full   <= (p_d == P_MAX);
      upd    <= (p_d != Pcount) || (t_d != Tcount);
    end
  end

`ifdef QUEUE_OVERFLOW_ALARM_EN
  logic overflow;

  // Any arrival event seen while full is a rejected arrival.
  assign overflow = ev_q[ENT] && (Pcount == P_MAX);

  // Sticky alarm; a new overflow beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)            alarm <= 1'b0;
    else if (overflow)  alarm <= 1'b1;
    else if (alarm_clr) alarm <= 1'b0;
  end
`endif

endmodule
